instruction_fetch_unit: RTL and testbench

Sequencer that owns the program counter and drives the 256x8 synchronous-read instruction ROM (registered output, 1-cycle read latency). It fetches opcodes plus an optional immediate byte and presents whole instructions to the control unit over a valid/ready handshake. It applies jumps at instruction acceptance and stops on the halt opcode.

---
 rtl/ifu_pkg.sv | 21 ++
 rtl/ifu_pc_counter.sv | 25 ++
 rtl/instruction_fetch_unit.sv | 149 ++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Optional build macro: IFU_INSTR_COUNT_EN (see instruction_fetch_unit).
package ifu_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;

  localparam logic [7:0] OPC_IMM  = 8'h1F;
  localparam logic [7:0] OPC_HALT = 8'h20;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    F_OP    = 3'd1,
    F_OP_W  = 3'd2,
    F_IMM   = 3'd3,
    F_IMM_W = 3'd4,
    PRESENT = 3'd5,
    HALTED  = 3'd6
  } ifu_state_e;

endpackage

// File: rtl/ifu_pc_counter.sv
// Program counter register: load has priority over increment; wraps modulo 2^ADDR_W.
module ifu_pc_counter #(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc
);

  // PC register: reset to RESET_PC, load a new target, or step by one
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= load_addr;
    end else if (inc) begin
      pc <= pc + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch sequencer: walks the PC over a 1-cycle-latency ROM,
// assembles opcode (+ optional immediate) and hands it over valid/ready.
// Optional build macro: IFU_INSTR_COUNT_EN adds a saturating 16-bit
// accepted-instruction counter on instr_count.
module instruction_fetch_unit
  import ifu_pkg::*;
#(
  parameter int                ADDR_W      = ADDR_W_DEF,
  parameter int                DATA_W      = DATA_W_DEF,
  parameter logic [DATA_W-1:0] IMM_OPCODE  = DATA_W'(OPC_IMM),
  parameter logic [DATA_W-1:0] HALT_OPCODE = DATA_W'(OPC_HALT),
  parameter logic [ADDR_W-1:0] RESET_PC    = '0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_q,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr_opcode,
  output logic [DATA_W-1:0] instr_imm,
  output logic              instr_has_imm,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_addr,
`ifdef IFU_INSTR_COUNT_EN
  output logic [15:0]       instr_count,
`endif
  output logic              busy,
  output logic              halted
);

  ifu_state_e        state, state_nxt;
  logic [ADDR_W-1:0] pc;
  logic              pc_load;
  logic [ADDR_W-1:0] pc_load_addr;
  logic              pc_inc;
  logic              cap_op;
  logic              cap_imm;
  logic              accept;
  logic              restart;

  ifu_pc_counter #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clock     (clock),
    .reset_n   (reset_n),
    .load      (pc_load),
    .load_addr (pc_load_addr),
    .inc       (pc_inc),
    .pc        (pc)
  );

  assign rom_addr    = pc;
  assign instr_valid = (state == PRESENT);
  assign busy        = (state != IDLE) && (state != HALTED);
  assign halted      = (state == HALTED);
  assign accept      = (state == PRESENT) && instr_ready;
  assign restart     = ((state == IDLE) || (state == HALTED)) && start;

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and PC control; ROM data is read in the *_W state after one held-address cycle
  always_comb begin
    state_nxt    = state;
    pc_load      = 1'b0;
    pc_load_addr = RESET_PC;
    pc_inc       = 1'b0;
    cap_op       = 1'b0;
    cap_imm      = 1'b0;
    case (state)
      IDLE, HALTED: begin
        if (start) begin
          state_nxt = F_OP;
          pc_load   = 1'b1;
        end
      end
      F_OP: state_nxt = F_OP_W;
      F_OP_W: begin
        cap_op    = 1'b1;
        pc_inc    = 1'b1;
        state_nxt = (rom_q == IMM_OPCODE) ? F_IMM : PRESENT;
      end
      F_IMM: state_nxt = F_IMM_W;
      F_IMM_W: begin
        cap_imm   = 1'b1;
        pc_inc    = 1'b1;
        state_nxt = PRESENT;
      end
      PRESENT: begin
        if (instr_ready) begin
          if (instr_opcode == HALT_OPCODE) begin
            state_nxt = HALTED;
          end else begin
            state_nxt = F_OP;
            if (jump_en) begin
              pc_load      = 1'b1;
              pc_load_addr = jump_addr;
            end
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Instruction field registers; held untouched while PRESENT waits for ready
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      instr_opcode  <= '0;
      instr_imm     <= '0;
      instr_has_imm <= 1'b0;
      instr_pc      <= '0;
    end else if (cap_op) begin
      instr_opcode  <= rom_q;
      instr_imm     <= '0;
      instr_has_imm <= (rom_q == IMM_OPCODE);
      instr_pc      <= pc;
    end else if (cap_imm) begin
      instr_imm     <= rom_q;
    end
  end

`ifdef IFU_INSTR_COUNT_EN
  // Accepted-instruction counter: cleared on start, saturates at all-ones
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      instr_count <= '0;
    end else if (restart) begin
      instr_count <= '0;
    end else if (accept && (instr_count != 16'hFFFF)) begin
      instr_count <= instr_count + 16'd1;
    end
  end
`else
  logic unused_restart;
  assign unused_restart = restart ^ accept;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a 256x8 registered-output ROM model.
module tb_instruction_fetch_unit;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       start;
  logic [7:0] rom_addr;
  logic [7:0] rom_q;
  logic       instr_valid;
  logic       instr_ready;
  logic [7:0] instr_opcode;
  logic [7:0] instr_imm;
  logic       instr_has_imm;
  logic [7:0] instr_pc;
  logic       jump_en;
  logic [7:0] jump_addr;
  logic       busy;
  logic       halted;
`ifdef IFU_INSTR_COUNT_EN
  logic [15:0] instr_count;
`endif

  logic [7:0] mem [0:255];

  int errors = 0;
  int checks = 0;

  instruction_fetch_unit dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .start         (start),
    .rom_addr      (rom_addr),
    .rom_q         (rom_q),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr_opcode  (instr_opcode),
    .instr_imm     (instr_imm),
    .instr_has_imm (instr_has_imm),
    .instr_pc      (instr_pc),
    .jump_en       (jump_en),
    .jump_addr     (jump_addr),
`ifdef IFU_INSTR_COUNT_EN
    .instr_count   (instr_count),
`endif
    .busy          (busy),
    .halted        (halted)
  );

  always #5 clock = ~clock;

  // Synchronous-read ROM, one cycle of latency
  always @(posedge clock) rom_q <= mem[rom_addr];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"},  instr_valid,   0);
    chk({tag, "_addr"},   rom_addr,      0);
    chk({tag, "_opcode"}, instr_opcode,  0);
    chk({tag, "_imm"},    instr_imm,     0);
    chk({tag, "_hasimm"}, instr_has_imm, 0);
    chk({tag, "_pc"},     instr_pc,      0);
    chk({tag, "_busy"},   busy,          0);
    chk({tag, "_halted"}, halted,        0);
`ifdef IFU_INSTR_COUNT_EN
    chk({tag, "_count"},  instr_count,   0);
`endif
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Wait (bounded) for instr_valid, then check latency and fields
  task automatic fetch_check(input string tag, input logic [7:0] op, input logic [7:0] imm,
                             input logic has, input logic [7:0] pc, input int lat);
    int n = 0;
    while (!instr_valid && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_lat"},    n,             lat);
    chk({tag, "_opcode"}, instr_opcode,  op);
    chk({tag, "_imm"},    instr_imm,     imm);
    chk({tag, "_hasimm"}, instr_has_imm, has);
    chk({tag, "_pc"},     instr_pc,      pc);
  endtask

  initial begin
    reset_n     = 1'b0;
    start       = 1'b0;
    instr_ready = 1'b0;
    jump_en     = 1'b0;
    jump_addr   = 8'h00;
    clear_mem();
    #1;
    check_reset_outputs("rst0");
    do_reset();

    // Three 1-byte instructions ending in halt
    mem[0] = 8'h06; mem[1] = 8'h0B; mem[2] = 8'h20;
    instr_ready = 1'b1;
    pulse_start();
    chk("t1_busy", busy, 1);
    fetch_check("t1_i0", 8'h06, 8'h00, 1'b0, 8'h00, 2);
    tick();
    fetch_check("t1_i1", 8'h0B, 8'h00, 1'b0, 8'h01, 2);
    tick();
    fetch_check("t1_i2", 8'h20, 8'h00, 1'b0, 8'h02, 2);
    tick();
    chk("t1_halted", halted, 1);
    chk("t1_valid", instr_valid, 0);
    chk("t1_busy_h", busy, 0);
    tick();
    tick();
    chk("t1_addr", rom_addr, 8'h03);
`ifdef IFU_INSTR_COUNT_EN
    chk("t1_count", instr_count, 3);
`endif

    // Immediate instruction, restarted from HALTED
    clear_mem();
    mem[0] = 8'h1F; mem[1] = 8'hFE; mem[2] = 8'h20;
    pulse_start();
    chk("t2_halted", halted, 0);
    fetch_check("t2_i0", 8'h1F, 8'hFE, 1'b1, 8'h00, 4);
    tick();
    fetch_check("t2_i1", 8'h20, 8'h00, 1'b0, 8'h02, 2);
    tick();
    chk("t2_halted2", halted, 1);

    // Backpressure: fields stable while ready is low; start ignored in PRESENT
    do_reset();
    clear_mem();
    mem[0] = 8'h06; mem[1] = 8'h0B; mem[2] = 8'h20;
    instr_ready = 1'b0;
    pulse_start();
    fetch_check("t3_i0", 8'h06, 8'h00, 1'b0, 8'h00, 2);
    for (int c = 0; c < 5; c++) begin
      start = (c == 2);
      tick();
      chk("t3_hold_valid", instr_valid, 1);
      chk("t3_hold_op", instr_opcode, 8'h06);
      chk("t3_hold_pc", instr_pc, 8'h00);
    end
    start = 1'b0;
    instr_ready = 1'b1;
    tick();
    chk("t3_drop_valid", instr_valid, 0);
    chk("t3_fop_addr", rom_addr, 8'h01);
    fetch_check("t3_i1", 8'h0B, 8'h00, 1'b0, 8'h01, 2);

    // Jumps: stray jump_en ignored, jump applied on acceptance at pc 3
    do_reset();
    clear_mem();
    mem[0] = 8'h06; mem[1] = 8'h0B; mem[2] = 8'h0C; mem[3] = 8'h0D;
    mem[8'h40] = 8'h20; mem[8'h5D] = 8'h07; mem[8'h5E] = 8'h20;
    instr_ready = 1'b0;
    jump_en = 1'b1;
    jump_addr = 8'h40;
    pulse_start();
    fetch_check("t4_i0", 8'h06, 8'h00, 1'b0, 8'h00, 2);
    tick();
    jump_en = 1'b0;
    instr_ready = 1'b1;
    tick();
    fetch_check("t4_i1", 8'h0B, 8'h00, 1'b0, 8'h01, 2);
    tick();
    fetch_check("t4_i2", 8'h0C, 8'h00, 1'b0, 8'h02, 2);
    tick();
    fetch_check("t4_i3", 8'h0D, 8'h00, 1'b0, 8'h03, 2);
    jump_en = 1'b1;
    jump_addr = 8'h5D;
    tick();
    jump_en = 1'b0;
    fetch_check("t4_j0", 8'h07, 8'h00, 1'b0, 8'h5D, 2);
    tick();
    fetch_check("t4_j1", 8'h20, 8'h00, 1'b0, 8'h5E, 2);
    tick();
    chk("t4_halted", halted, 1);

    // Jump to FF: immediate wraps to address 00
    do_reset();
    clear_mem();
    mem[0] = 8'hAA; mem[1] = 8'h20; mem[8'hFF] = 8'h1F;
    pulse_start();
    fetch_check("t5_i0", 8'hAA, 8'h00, 1'b0, 8'h00, 2);
    jump_en = 1'b1;
    jump_addr = 8'hFF;
    tick();
    jump_en = 1'b0;
    fetch_check("t5_ff", 8'h1F, 8'hAA, 1'b1, 8'hFF, 4);
    tick();
    fetch_check("t5_wrap", 8'h20, 8'h00, 1'b0, 8'h01, 2);
    tick();
    chk("t5_halted", halted, 1);

    // Reset in the middle of an immediate fetch
    do_reset();
    clear_mem();
    mem[0] = 8'h1F; mem[1] = 8'hFE; mem[2] = 8'h20;
    pulse_start();
    fetch_check("t6_pre", 8'h1F, 8'hFE, 1'b1, 8'h00, 4);
    tick();
    fetch_check("t6_pre2", 8'h20, 8'h00, 1'b0, 8'h02, 2);
    tick();
    pulse_start();
    tick();
    tick();
    tick();
    chk("t6_busy", busy, 1);
    chk("t6_opcode_mid", instr_opcode, 8'h1F);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("t6_rst");
    #2;
    reset_n = 1'b1;
    tick();
    check_reset_outputs("t6_after");
    pulse_start();
    fetch_check("t6_restart", 8'h1F, 8'hFE, 1'b1, 8'h00, 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
